coproc_cmd_sequencer: RTL and testbench

- Sequential front end that drives the matrix convolution coprocessor.
- Accepts host instructions over a valid/ready channel and loads matrix A, B (Gx/Laplacian kernel) and C (Gy kernel) one row at a time.
- Issues the Laplacian (3'b110) or Gradient (3'b111) op code, waits for process_Done, captures the result and returns one response per instruction.
- Sits between the HPS-side bridge and the combinational coprocessor.

---
 rtl/coproc_seq_pkg.sv | 32 +++
 rtl/coproc_matrix_regfile.sv | 40 ++++
 rtl/coproc_cmd_sequencer.sv | 152 +++++++++++++++
 tb/tb_coproc_cmd_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_seq_pkg.sv
// Shared constants, state encoding and helpers for the coprocessor command sequencer.
package coproc_seq_pkg;

  localparam int unsigned ELEM_W    = 8;
  localparam int unsigned ROW_ELEMS = 5;
  localparam int unsigned ROW_W     = ELEM_W * ROW_ELEMS;
  localparam int unsigned MAT_W     = ROW_W * ROW_ELEMS;

  localparam logic [2:0] OP_NOP       = 3'b000;
  localparam logic [2:0] OP_LOAD_ROW  = 3'b001;
  localparam logic [2:0] OP_CLEAR     = 3'b010;
  localparam logic [2:0] OP_LAPLACIAN = 3'b110;
  localparam logic [2:0] OP_GRADIENT  = 3'b111;

  localparam logic [1:0] SEL_A       = 2'd0;
  localparam logic [1:0] SEL_B       = 2'd1;
  localparam logic [1:0] SEL_C       = 2'd2;
  localparam logic [1:0] SEL_ILLEGAL = 2'd3;

  localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } seq_state_e;

  function automatic logic load_legal(input logic [1:0] sel, input logic [2:0] row);
    return (sel != SEL_ILLEGAL) && (row < 3'(ROW_ELEMS));
  endfunction

endpackage

// File: rtl/coproc_matrix_regfile.sv
// Storage for matrices A, B and C: single-row write port plus a whole-file clear strobe.
module coproc_matrix_regfile
  import coproc_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [2:0]       wr_row,
  input  logic [ROW_W-1:0] wr_data,
  input  logic             clr,
  output logic [MAT_W-1:0] mat_a,
  output logic [MAT_W-1:0] mat_b,
  output logic [MAT_W-1:0] mat_c
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_a <= '0;
      mat_b <= '0;
      mat_c <= '0;
    end else if (clr) begin
      mat_a <= '0;
      mat_b <= '0;
      mat_c <= '0;
    end else if (wr_en) begin
      for (int unsigned r = 0; r < ROW_ELEMS; r++) begin
        if (wr_row == r[2:0]) begin
          case (wr_sel)
            SEL_A:   mat_a[r*ROW_W +: ROW_W] <= wr_data;
            SEL_B:   mat_b[r*ROW_W +: ROW_W] <= wr_data;
            SEL_C:   mat_c[r*ROW_W +: ROW_W] <= wr_data;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/coproc_cmd_sequencer.sv
// Host-instruction front end for the matrix convolution coprocessor (IDLE/WAIT/RESP FSM).
// Optional WAIT watchdog enabled by defining COPROC_SEQ_TIMEOUT_EN.
module coproc_cmd_sequencer
  import coproc_seq_pkg::*;
`ifdef COPROC_SEQ_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_opcode,
  input  logic [1:0]       instr_sel,
  input  logic [2:0]       instr_row,
  input  logic [1:0]       instr_size,
  input  logic [ROW_W-1:0] instr_data,
  output logic [2:0]       cp_op_code,
  output logic [1:0]       cp_matrix_size,
  output logic [MAT_W-1:0] cp_matrix_a,
  output logic [MAT_W-1:0] cp_matrix_b,
  output logic [MAT_W-1:0] cp_matrix_c,
  input  logic             cp_process_Done,
  input  logic [MAT_W-1:0] cp_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             rsp_error
);

  seq_state_e  state_q, state_d;
  logic [2:0]  op_d;
  logic [1:0]  size_d;
  logic [15:0] data_d;
  logic        err_d;
  logic        wr_en;
  logic        clr;
  logic        unused_result_hi;

`ifdef COPROC_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign unused_result_hi = ^cp_result[MAT_W-1:16];

  assign instr_ready = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);

  coproc_matrix_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_sel  (instr_sel),
    .wr_row  (instr_row),
    .wr_data (instr_data),
    .clr     (clr),
    .mat_a   (cp_matrix_a),
    .mat_b   (cp_matrix_b),
    .mat_c   (cp_matrix_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cp_op_code     <= OP_NOP;
      cp_matrix_size <= '0;
      rsp_data       <= '0;
      rsp_error      <= 1'b0;
`ifdef COPROC_SEQ_TIMEOUT_EN
      cnt_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cp_op_code     <= op_d;
      cp_matrix_size <= size_d;
      rsp_data       <= data_d;
      rsp_error      <= err_d;
`ifdef COPROC_SEQ_TIMEOUT_EN
      cnt_q          <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = cp_op_code;
    size_d  = cp_matrix_size;
    data_d  = rsp_data;
    err_d   = rsp_error;
    wr_en   = 1'b0;
    clr     = 1'b0;
`ifdef COPROC_SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          state_d = S_RESP;
          data_d  = '0;
          err_d   = 1'b0;
          case (instr_opcode)
            OP_NOP: ;
            OP_LOAD_ROW: begin
              if (load_legal(instr_sel, instr_row)) wr_en = 1'b1;
              else                                  err_d = 1'b1;
            end
            OP_CLEAR: clr = 1'b1;
            OP_LAPLACIAN, OP_GRADIENT: begin
              op_d    = instr_opcode;
              size_d  = instr_size;
              state_d = S_WAIT;
`ifdef COPROC_SEQ_TIMEOUT_EN
              cnt_d   = '0;
`endif
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_WAIT: begin
        if (cp_process_Done) begin
          // Gradient magnitude is an unsigned byte; Laplacian keeps its signed 16-bit form.
          data_d  = (cp_op_code == OP_GRADIENT) ? {8'h00, cp_result[7:0]} : cp_result[15:0];
          op_d    = OP_NOP;
          state_d = S_RESP;
        end
`ifdef COPROC_SEQ_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          data_d  = TIMEOUT_DATA;
          err_d   = 1'b1;
          op_d    = OP_NOP;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_coproc_cmd_sequencer.sv
// Directed self-checking bench for coproc_cmd_sequencer with a combinational coprocessor stand-in.
module tb_coproc_cmd_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         instr_valid = 1'b0;
  logic         instr_ready;
  logic [2:0]   instr_opcode = '0;
  logic [1:0]   instr_sel = '0;
  logic [2:0]   instr_row = '0;
  logic [1:0]   instr_size = '0;
  logic [39:0]  instr_data = '0;
  logic [2:0]   cp_op_code;
  logic [1:0]   cp_matrix_size;
  logic [199:0] cp_matrix_a, cp_matrix_b, cp_matrix_c;
  logic         cp_process_Done;
  logic [199:0] cp_result;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [15:0]  rsp_data;
  logic         rsp_error;

  logic         done_en = 1'b0;
  logic [199:0] model_result = '0;
  logic [199:0] exp_a = '0, exp_b = '0, exp_c = '0;
  int           passed = 0;
  int           total = 0;

  always #5 clk = ~clk;

  // Coprocessor stand-in: finishes immediately whenever an op code is presented.
  assign cp_process_Done = done_en && (cp_op_code != 3'b000);
  assign cp_result       = model_result;

  coproc_cmd_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_opcode    (instr_opcode),
    .instr_sel       (instr_sel),
    .instr_row       (instr_row),
    .instr_size      (instr_size),
    .instr_data      (instr_data),
    .cp_op_code      (cp_op_code),
    .cp_matrix_size  (cp_matrix_size),
    .cp_matrix_a     (cp_matrix_a),
    .cp_matrix_b     (cp_matrix_b),
    .cp_matrix_c     (cp_matrix_c),
    .cp_process_Done (cp_process_Done),
    .cp_result       (cp_result),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_error       (rsp_error)
  );

  task automatic send(input logic [2:0] op, input logic [1:0] sel, input logic [2:0] row,
                      input logic [1:0] size, input logic [39:0] data);
    @(negedge clk);
    instr_valid  = 1'b1;
    instr_opcode = op;
    instr_sel    = sel;
    instr_row    = row;
    instr_size   = size;
    instr_data   = data;
    @(posedge clk);
    #1;
    instr_valid  = 1'b0;
  endtask

  task automatic load_row(input logic [1:0] sel, input logic [2:0] row, input logic [39:0] data);
    send(3'b001, sel, row, 2'd0, data);
    if (row <= 3'd4) begin
      case (sel)
        2'd0: exp_a[int'(row)*40 +: 40] = data;
        2'd1: exp_b[int'(row)*40 +: 40] = data;
        2'd2: exp_c[int'(row)*40 +: 40] = data;
        default: ;
      endcase
    end
  endtask

  task automatic ack;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (instr_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", instr_ready); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); else passed++;
    total++; if ({rsp_data, rsp_error} !== 17'h0) $display("FAIL reset_rsp got %h/%b exp 0/0", rsp_data, rsp_error); else passed++;
    total++; if ({cp_op_code, cp_matrix_size} !== 5'h0) $display("FAIL reset_cp got %b/%b exp 000/00", cp_op_code, cp_matrix_size); else passed++;
    total++; if ({cp_matrix_a, cp_matrix_b, cp_matrix_c} !== 600'h0) $display("FAIL reset_matrices got nonzero exp 0"); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_row;
    load_row(2'd0, 3'd2, 40'h0504030201);
    total++; if (rsp_valid !== 1'b1) $display("FAIL load_latency got %b exp 1", rsp_valid); else passed++;
    total++; if (cp_matrix_a[87:80] !== 8'h01) $display("FAIL load_a_r2c0 got %h exp 01", cp_matrix_a[87:80]); else passed++;
    total++; if (cp_matrix_a[119:112] !== 8'h05) $display("FAIL load_a_r2c4 got %h exp 05", cp_matrix_a[119:112]); else passed++;
    total++; if ({rsp_error, rsp_data} !== 17'h0) $display("FAIL load_rsp got %b/%h exp 0/0000", rsp_error, rsp_data); else passed++;
    total++; if (instr_ready !== 1'b0) $display("FAIL load_ready_in_resp got %b exp 0", instr_ready); else passed++;
    ack();
    total++; if ({rsp_valid, instr_ready} !== 2'b01) $display("FAIL load_ack got %b%b exp 01", rsp_valid, instr_ready); else passed++;
  endtask

  task automatic test_laplacian;
    for (int r = 0; r < 5; r++) begin
      load_row(2'd0, 3'(r), 40'h0101010101);
      ack();
    end
    load_row(2'd1, 3'd0, 40'h0000000100); ack();
    load_row(2'd1, 3'd1, 40'h000001FC01); ack();
    load_row(2'd1, 3'd2, 40'h0000000100); ack();
    total++; if (cp_matrix_a !== exp_a) $display("FAIL lap_matrix_a got %h exp %h", cp_matrix_a, exp_a); else passed++;
    total++; if (cp_matrix_b !== exp_b) $display("FAIL lap_matrix_b got %h exp %h", cp_matrix_b, exp_b); else passed++;
    model_result = {184'h0, 16'hFFFC};
    done_en = 1'b1;
    send(3'b110, 2'd0, 3'd0, 2'd1, 40'h0);
    total++; if ({rsp_valid, instr_ready} !== 2'b00) $display("FAIL lap_wait got %b%b exp 00", rsp_valid, instr_ready); else passed++;
    total++; if ({cp_op_code, cp_matrix_size} !== {3'b110, 2'd1}) $display("FAIL lap_issue got %b/%d exp 110/1", cp_op_code, cp_matrix_size); else passed++;
    @(posedge clk);
    #1;
    total++; if (rsp_valid !== 1'b1) $display("FAIL lap_latency got %b exp 1", rsp_valid); else passed++;
    total++; if ({rsp_error, rsp_data} !== {1'b0, 16'hFFFC}) $display("FAIL lap_rsp got %b/%h exp 0/fffc", rsp_error, rsp_data); else passed++;
    total++; if ({cp_op_code, cp_matrix_size} !== {3'b000, 2'd1}) $display("FAIL lap_opclr got %b/%d exp 000/1", cp_op_code, cp_matrix_size); else passed++;
    ack();
  endtask

  task automatic test_gradient_hold;
    model_result = {184'hA5A5, 16'h12FF};
    done_en = 1'b1;
    send(3'b111, 2'd0, 3'd0, 2'd3, 40'h0);
    total++; if (cp_op_code !== 3'b111) $display("FAIL grad_issue got %b exp 111", cp_op_code); else passed++;
    @(posedge clk);
    #1;
    total++; if ({rsp_valid, rsp_error, rsp_data} !== {2'b10, 16'h00FF}) $display("FAIL grad_rsp got %b/%b/%h exp 1/0/00ff", rsp_valid, rsp_error, rsp_data); else passed++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      instr_valid  = i[0];
      instr_opcode = 3'b001;
      instr_sel    = 2'd0;
      instr_row    = 3'd0;
      instr_data   = 40'hFFFFFFFFFF;
      @(posedge clk);
      #1;
      total++; if ({rsp_valid, rsp_data, instr_ready} !== {1'b1, 16'h00FF, 1'b0}) $display("FAIL hold_cycle%0d got %b/%h/%b exp 1/00ff/0", i, rsp_valid, rsp_data, instr_ready); else passed++;
    end
    instr_valid = 1'b0;
    total++; if (cp_matrix_a !== exp_a) $display("FAIL hold_no_write got %h exp %h", cp_matrix_a, exp_a); else passed++;
    ack();
    total++; if ({rsp_valid, rsp_error, instr_ready} !== 3'b001) $display("FAIL hold_release got %b%b%b exp 001", rsp_valid, rsp_error, instr_ready); else passed++;
  endtask

  task automatic test_errors;
    load_row(2'd3, 3'd0, 40'h1111111111);
    total++; if ({rsp_valid, rsp_error, rsp_data} !== {2'b11, 16'h0}) $display("FAIL err_sel3 got %b/%b/%h exp 1/1/0000", rsp_valid, rsp_error, rsp_data); else passed++;
    ack();
    load_row(2'd0, 3'd5, 40'h2222222222);
    total++; if ({rsp_valid, rsp_error} !== 2'b11) $display("FAIL err_row5 got %b/%b exp 1/1", rsp_valid, rsp_error); else passed++;
    ack();
    send(3'b011, 2'd0, 3'd0, 2'd0, 40'h0);
    total++; if ({rsp_valid, rsp_error, rsp_data} !== {2'b11, 16'h0}) $display("FAIL err_op011 got %b/%b/%h exp 1/1/0000", rsp_valid, rsp_error, rsp_data); else passed++;
    ack();
    total++; if ({cp_matrix_a, cp_matrix_b, cp_matrix_c} !== {exp_a, exp_b, exp_c}) $display("FAIL err_matrices_unchanged got %h exp %h", cp_matrix_a, exp_a); else passed++;
    load_row(2'd2, 3'd4, 40'hA1B2C3D4E5);
    total++; if ({rsp_error, cp_matrix_c} !== {1'b0, exp_c}) $display("FAIL load_c_row4 got %b/%h exp 0/%h", rsp_error, cp_matrix_c, exp_c); else passed++;
    ack();
  endtask

  task automatic test_clear;
    send(3'b010, 2'd0, 3'd0, 2'd0, 40'h0);
    exp_a = '0; exp_b = '0; exp_c = '0;
    total++; if ({rsp_valid, rsp_error} !== 2'b10) $display("FAIL clear_rsp got %b/%b exp 1/0", rsp_valid, rsp_error); else passed++;
    total++; if ({cp_matrix_a, cp_matrix_b, cp_matrix_c} !== 600'h0) $display("FAIL clear_matrices got nonzero exp 0"); else passed++;
    ack();
  endtask

`ifdef COPROC_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    done_en = 1'b0;
    send(3'b111, 2'd0, 3'd0, 2'd2, 40'h0);
    n = 0;
    while (!rsp_valid && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++; if (n !== 255) $display("FAIL timeout_cycles got %0d exp 255", n); else passed++;
    total++; if ({rsp_error, rsp_data, cp_op_code} !== {1'b1, 16'hFFFF, 3'b000}) $display("FAIL timeout_rsp got %b/%h/%b exp 1/ffff/000", rsp_error, rsp_data, cp_op_code); else passed++;
    ack();
  endtask
`endif

  task automatic test_reset_mid_wait;
    load_row(2'd0, 3'd1, 40'h0A0B0C0D0E);
    ack();
    done_en = 1'b0;
    send(3'b110, 2'd0, 3'd0, 2'd2, 40'h0);
    repeat (4) @(posedge clk);
    #1;
    total++; if ({rsp_valid, instr_ready, cp_op_code} !== {2'b00, 3'b110}) $display("FAIL midwait_state got %b%b/%b exp 00/110", rsp_valid, instr_ready, cp_op_code); else passed++;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_a = '0; exp_b = '0; exp_c = '0;
    total++; if ({instr_ready, rsp_valid, rsp_error} !== 3'b100) $display("FAIL async_reset_ctrl got %b%b%b exp 100", instr_ready, rsp_valid, rsp_error); else passed++;
    total++; if ({cp_op_code, cp_matrix_size} !== 5'h0) $display("FAIL async_reset_cp got %b/%d exp 000/0", cp_op_code, cp_matrix_size); else passed++;
    total++; if ({cp_matrix_a, cp_matrix_b, cp_matrix_c} !== 600'h0) $display("FAIL async_reset_matrices got nonzero exp 0"); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    send(3'b000, 2'd0, 3'd0, 2'd0, 40'h0);
    total++; if ({rsp_valid, rsp_error, rsp_data} !== {2'b10, 16'h0}) $display("FAIL post_reset_nop got %b/%b/%h exp 1/0/0000", rsp_valid, rsp_error, rsp_data); else passed++;
    ack();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_row();
    test_laplacian();
    test_gradient_hold();
    test_errors();
    test_clear();
`ifdef COPROC_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
